// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian instruction words from a
// length/payload/XOR-checksum frame and holds the CPU in reset until a load succeeds.
module imem_loader #(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [INST_WIDTH-1:0] wr_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);
    localparam int BYTES  = INST_WIDTH / 8;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t                r_state, w_next;
    logic [7:0]            r_len_lo;
    logic [15:0]           r_len;
    logic [7:0]            r_xor;
    logic [BIDX_W-1:0]     r_byte_idx;
    logic [ADDR_WIDTH:0]   r_addr;
    logic [INST_WIDTH-1:0] r_word;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [INST_WIDTH-1:0] r_wr_data;
    logic                  r_hold;

    logic                  w_in_ready;
    logic                  w_xfer;
    logic                  w_start_ok;
    logic                  w_last_byte;
    logic                  w_last_word;
    logic                  w_len_big;
    logic [15:0]           w_len;
    logic [INST_WIDTH-1:0] w_word;

    assign w_xfer      = in_valid && w_in_ready;
    assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
    assign w_last_byte = (r_byte_idx == LAST_IDX);
    assign w_last_word = (32'(r_addr) + 32'd1 == 32'(r_len));
    assign w_len       = {in_data, r_len_lo};
    // Capacity is exactly 2^ADDR_WIDTH words, so N equal to that is still legal.
    assign w_len_big   = (32'(w_len) > (32'd1 << ADDR_WIDTH));

    always_comb begin
        w_word = r_word;
        w_word[32'(r_byte_idx) * 8 +: 8] = in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                w_in_ready = 1'b1;
                if (in_valid) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    if (w_len == 16'd0)  w_next = S_CHECK;
                    else if (w_len_big)  w_next = S_ERROR;
                    else                 w_next = S_DATA;
                end
            end
            S_DATA: begin
                w_in_ready = 1'b1;
                if (in_valid && w_last_byte && w_last_word) w_next = S_CHECK;
            end
            S_CHECK: begin
                w_in_ready = 1'b1;
                if (in_valid) w_next = (in_data == r_xor) ? S_DONE : S_ERROR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len_lo   <= '0;
            r_len      <= '0;
            r_xor      <= '0;
            r_byte_idx <= '0;
            r_addr     <= '0;
            r_word     <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_hold     <= 1'b1;
        end else begin
            r_wr_en <= 1'b0;
            if (w_start_ok) begin
                r_xor      <= '0;
                r_byte_idx <= '0;
                r_addr     <= '0;
                r_wr_addr  <= '0;
                r_hold     <= 1'b1;
            end else if (r_state == S_DONE) begin
                r_hold <= 1'b0;
            end
            if (w_xfer) begin
                if (r_state != S_CHECK) r_xor <= r_xor ^ in_data;
                case (r_state)
                    S_LEN_LO: r_len_lo <= in_data;
                    S_LEN_HI: r_len    <= w_len;
                    S_DATA: begin
                        r_word <= w_word;
                        if (w_last_byte) begin
                            r_byte_idx <= '0;
                            r_wr_en    <= 1'b1;
                            r_wr_data  <= w_word;
                            r_wr_addr  <= r_addr[ADDR_WIDTH-1:0];
                            r_addr     <= r_addr + (ADDR_WIDTH+1)'(1);
                        end else begin
                            r_byte_idx <= r_byte_idx + BIDX_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready = w_in_ready;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign cpu_hold = r_hold;
    assign done     = (r_state == S_DONE);
    assign error    = (r_state == S_ERROR);
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: frames are built from the frame rules, and the
// expected write stream and status outputs are derived from them.
module tb_imem_loader;
    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    imem_loader #(.INST_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
        .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          addr;
        logic [31:0] data;
    } due_t;

    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    bit          mon_en  = 0;
    due_t        due_q[$];
    logic [7:0]  pay[$];
    logic [7:0]  frm[$];
    logic [31:0] wordv[$];
    int          frm_n;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Every write must land exactly one cycle after its last byte, in order.
    always @(negedge clk) begin
        if (mon_en) begin
            if (due_q.size() > 0 && due_q[0].cyc == cyc) begin
                check("wr_en_pulse", 64'(wr_en), 64'd1);
                check("wr_addr", 64'(wr_addr), 64'(due_q[0].addr));
                check("wr_data", 64'(wr_data), 64'(due_q[0].data));
                void'(due_q.pop_front());
            end else begin
                check("wr_en_quiet", 64'(wr_en), 64'd0);
            end
        end
    end

    task automatic make_frame(input int n, input bit bad);
        logic [7:0]  c;
        logic [31:0] w;
        frm   = {};
        wordv = {};
        frm.push_back(8'(n));
        frm.push_back(8'(n >> 8));
        for (int k = 0; k < n; k++) begin
            w = 32'd0;
            for (int j = 0; j < 4; j++) begin
                frm.push_back(pay[k*4 + j]);
                w = w | (32'(pay[k*4 + j]) << (8 * j));
            end
            wordv.push_back(w);
        end
        c = 8'd0;
        foreach (frm[i]) c = c ^ frm[i];
        frm.push_back(bad ? ~c : c);
        frm_n = n;
    endtask

    task automatic fill_pay(input int nbytes);
        pay = {};
        for (int i = 0; i < nbytes; i++) pay.push_back(8'($urandom));
    endtask

    task automatic do_start();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = frm[0];
        check("start_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send_bytes(input int nbytes, input bit gaps);
        int pos   = 0;
        int guard = 0;
        int p;
        while (pos < nbytes && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = frm[pos];
                if (in_ready) begin
                    p = pos - 2;
                    if (pos >= 2 && p < frm_n * 4 && (p % 4) == 3)
                        due_q.push_back('{cyc + 1, p / 4, wordv[p / 4]});
                    pos++;
                end
            end
        end
        if (pos < nbytes) check("send_timeout", 64'(pos), 64'(nbytes));
    endtask

    task automatic finish_frame(input bit good);
        @(negedge clk);
        in_valid = 1'b0;
        check("done", 64'(done), 64'(good));
        check("error", 64'(error), 64'(!good));
        check("hold_t1", 64'(cpu_hold), 64'd1);
        @(negedge clk);
        check("hold_t2", 64'(cpu_hold), 64'(!good));
        check("in_ready_end", 64'(in_ready), 64'd0);
    endtask

    task automatic run_frame(input int n, input bit bad, input bit gaps);
        make_frame(n, bad);
        do_start();
        send_bytes(frm.size(), gaps);
        finish_frame(!bad);
    endtask

    initial begin
        bit bad;
        int n;
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(negedge clk);
        reset  = 1'b1;
        mon_en = 1;

        // Idle with bytes offered: nothing consumed, nothing written.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            check("idle_in_ready", 64'(in_ready), 64'd0);
            check("idle_hold", 64'(cpu_hold), 64'd1);
            check("idle_done", 64'(done), 64'd0);
            check("idle_error", 64'(error), 64'd0);
            check("idle_wr_addr", 64'(wr_addr), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;

        // Directed two-word frame; model pinned against hand-computed values.
        pay = {8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        make_frame(2, 1'b0);
        check("model_chk", 64'(frm[10]), 64'h46);
        check("model_w0", 64'(wordv[0]), 64'h44332211);
        check("model_w1", 64'(wordv[1]), 64'hDDCCBBAA);
        run_frame(2, 1'b0, 1'b0);

        // Same frame with a bad checksum, then a good reload.
        run_frame(2, 1'b1, 1'b0);
        run_frame(2, 1'b0, 1'b1);

        // Empty program.
        run_frame(0, 1'b0, 1'b0);

        // Oversized length: rejected right after the length bytes.
        frm   = {8'h01, 8'h01};
        frm_n = 0;
        do_start();
        send_bytes(2, 1'b0);
        @(negedge clk);
        check("len_big_error", 64'(error), 64'd1);
        check("len_big_done", 64'(done), 64'd0);
        check("len_big_ready", 64'(in_ready), 64'd0);
        check("len_big_hold", 64'(cpu_hold), 64'd1);
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("len_big_stays", 64'(error), 64'd1);
        in_valid = 1'b0;

        // Full capacity: 256 words, addresses 0..255.
        fill_pay(1024);
        run_frame(256, 1'b0, 1'b0);

        // Random frames with random valid gaps and occasional bad checksums.
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, 20);
            bad = ($urandom_range(0, 3) == 0);
            fill_pay(n * 4);
            run_frame(n, bad, 1'b1);
        end

        // Reset two bytes into word 1: word 0 already written, nothing after.
        fill_pay(12);
        make_frame(3, 1'b0);
        do_start();
        send_bytes(8, 1'b0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_hold", 64'(cpu_hold), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_after_addr", 64'(wr_addr), 64'd0);
        check("rst_after_ready", 64'(in_ready), 64'd0);
        check("due_drained", 64'(due_q.size()), 64'd0);

        mon_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the instruction memory read path: receives a framed byte stream, assembles little-endian instruction words and writes them through the instruction memory's write port.
- Holds the CPU in reset while a program is loading. On a valid load it releases the CPU, which then starts fetching at PC 0.
- Sits between the host/debug byte link and the instr_mem write port. It is driven from the same clock as the cpu.

Parameters:
- INST_WIDTH, 32, instruction word width in bits; must be a multiple of 8, from 8 to 64.
- ADDR_WIDTH, 8, instruction memory address width; capacity is 2^ADDR_WIDTH words.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERROR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle. A transfer occurs when in_valid && in_ready.
- wr_en  out  1  instruction memory write strobe, one cycle per word.
- wr_addr  out  ADDR_WIDTH  word address.
- wr_data  out  INST_WIDTH  assembled instruction word.
- cpu_hold  out  1  keeps the CPU in reset while high.
- done  out  1  load completed and checksum matched. Level output.
- error  out  1  load aborted. Level output.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, done=0, error=0.
  - cpu_hold=1: the CPU stays held until the first successful load.
- Frame format, in byte order:
  - LEN_LO, LEN_HI: 16-bit word count N.
  - N*(INST_WIDTH/8) payload bytes, little-endian within each word.
  - CHK: XOR of every preceding frame byte, length bytes included.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
- start in IDLE, DONE or ERROR:
  - Go to LEN_LO.
  - Set cpu_hold=1; clear done and error.
  - Reset the running XOR, byte index and word address to 0.
  - start in any other state is ignored.
- in_ready=1 only in LEN_LO, LEN_HI, DATA and CHECK; 0 elsewhere. Bytes offered while in_ready=0 are not consumed.
- LEN_LO, on transfer: latch the low byte and go to LEN_HI.
- LEN_HI, on transfer, with the high byte latched:
  - N=0: go to CHECK.
  - N > 2^ADDR_WIDTH: go to ERROR.
  - Otherwise: go to DATA.
- DATA:
  - Each transfer shifts the byte into lane [byte_idx*8 +: 8] of the word register.
  - On the last byte of a word, wr_en pulses on the following cycle, with wr_data holding the complete word and wr_addr the current word index.
  - wr_addr then increments. No wrap is possible, because N is bounded by 2^ADDR_WIDTH; the address counter is ADDR_WIDTH+1 bits internally.
  - After word N-1 the state goes to CHECK. A byte can be accepted in the same cycle the previous word's wr_en is high, so there are no bubbles.
- CHECK, on transfer:
  - Byte equals the running XOR: go to DONE, set done=1, and cpu_hold falls on the next cycle.
  - Otherwise: go to ERROR.
- ERROR: error=1, cpu_hold remains 1, and the state holds until the next start.
- Memory contents already written are not rolled back on error; cpu_hold prevents them being executed.
- wr_en is never high outside DATA or the cycle immediately after it.
- Reset asserted mid-load: immediate return to the reset state. Any word half-assembled is discarded; any write already issued stays in memory.
- Simultaneous start and in_valid in IDLE: start is taken; the byte is not consumed (in_ready=0 that cycle).
- Latency: last byte of a word accepted at cycle t → wr_en at t+1. CHK byte accepted at t → done=1 at t+1, cpu_hold=0 at t+2.

Test Plan:
- Reset then idle → cpu_hold=1, in_ready=0, done=0, error=0; no wr_en for 20 cycles while in_valid=1.
- start; bytes 02 00, 11 22 33 44, AA BB CC DD, CHK=(02^00^11^22^33^44^AA^BB^CC^DD) → writes addr0=0x44332211 and addr1=0xDDCCBBAA, done=1, cpu_hold=0.
- Same frame with CHK inverted → both writes occur, error=1, done=0, cpu_hold=1. A following start plus a good frame → done=1.
- start; N=0 frame (00 00 00) → no wr_en, done=1. With ADDR_WIDTH=8, N=0x0101 → error=1 immediately after LEN_HI, no writes.
- Random in_valid gaps and a byte presented every cycle → exactly N wr_en pulses with consecutive addresses; no byte lost or duplicated.
- Reset asserted after 2 bytes of word 1 → state IDLE, wr_addr=0, no further wr_en; word 0 is still in memory.
